fir_output_stage: RTL and testbench



---
 rtl/fir_pkg.sv | 41 ++++
 rtl/fir_out_fifo.sv | 72 +++++++
 rtl/fir_output_stage.sv | 141 ++++++++++++++
 tb/tb_fir_output_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared widths, sample type and the round/saturate helper for the FIR output path.
// Latency: purely combinational helper, adds no cycles of its own.
// Backpressure: none here; flow control lives in the stage and its FIFO.
package fir_pkg;

  localparam int SUM_W     = 32;
  localparam int OUT_W_DEF = 16;

  typedef struct packed {
    logic                        sat;
    logic signed [OUT_W_DEF-1:0] data;
  } sample_t;

  // Round half up, arithmetic shift right, then clamp to the signed output range.
  // Working width is one bit wider than the sum so the rounding add never wraps.
  function automatic sample_t fir_round_sat(input logic signed [SUM_W-1:0] sum,
                                            input int unsigned             shift);
    logic signed [SUM_W:0] ext;
    logic signed [SUM_W:0] rnd;
    logic signed [SUM_W:0] t;
    logic signed [SUM_W:0] hi;
    logic signed [SUM_W:0] lo;
    sample_t               res;
    ext      = {sum[SUM_W-1], sum};
    rnd      = (SUM_W+1)'(1) << (shift - 1);
    t        = (ext + rnd) >>> shift;
    hi       = (SUM_W+1)'(2**(OUT_W_DEF-1) - 1);
    lo       = ~hi;
    res.sat  = 1'b0;
    res.data = t[OUT_W_DEF-1:0];
    if (t > hi) begin
      res.sat  = 1'b1;
      res.data = {1'b0, {(OUT_W_DEF-1){1'b1}}};
    end else if (t < lo) begin
      res.sat  = 1'b1;
      res.data = {1'b1, {(OUT_W_DEF-1){1'b0}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous sample FIFO with a registered head word.
// Latency: a push into an empty FIFO is visible at the head on the next cycle.
// Backpressure: pop only when non-empty; a push while full is accepted only with a same-cycle pop.
module fir_out_fifo #(
  parameter  int W     = 17,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk3,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  wdat_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdat_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointers, occupancy and head word; the head reloads from the array
  // after a pop, or takes the incoming word when it becomes the only entry.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
    head_d   = head_q;
    if (do_push && (level_q == LW'(do_pop))) begin
      head_d = wdat_i;
    end else if (level_q > LW'(do_pop)) begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array; contents are only meaningful under the occupancy count.
  always_ff @(posedge clk3) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdat_i;
    end
  end

  // Pointer, occupancy and head registers.
  always_ff @(posedge clk3) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  assign rdat_o  = head_q;
  assign level_o = level_q;

endmodule

// File: rtl/fir_output_stage.sv
// Captures one FIR sum per correctly spaced load pulse, rounds/saturates it and queues it.
// Latency: pulse in cycle T -> stage at end of T -> FIFO write end of T+1 -> out_valid in T+2.
// Backpressure: out_ready stalls the FIFO head; a result arriving while full is dropped and flagged.
module fir_output_stage
  import fir_pkg::*;
#(
  parameter  int FRAME_LEN = 16,
  parameter  int SHIFT     = 15,
  parameter  int OUT_W     = OUT_W_DEF,
  parameter  int DEPTH     = 8,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                    clk3,
  input  logic                    reset,
  input  logic signed [SUM_W-1:0] sum_in,
  input  logic                    load_pulse,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LW-1:0]           level,
  output logic                    overflow,
  output logic                    frame_err,
  input  logic                    clr_flags
);

  localparam int              PH_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(FRAME_LEN - 1);

  logic [PH_W-1:0]         phase_q, phase_d;
  logic                    armed_q, armed_d;
  logic                    stg_vld_q, stg_vld_d;
  logic signed [SUM_W-1:0] stg_sum_q, stg_sum_d;
  logic                    ovf_q, ovf_d;
  logic                    ferr_q, ferr_d;

  logic                    frame_ok, capture, bad_pulse;
  logic signed [OUT_W-1:0] scl_data;
  logic                    scl_sat;
  logic [OUT_W:0]          fifo_rdat;
  logic                    fifo_full, fifo_empty, fifo_pop;

  // A frame is complete only once the phase counter has reached its last slot;
  // the very first pulse after reset just arms, since no frame has finished yet.
  assign frame_ok  = (phase_q == PH_LAST);
  assign capture   = load_pulse && armed_q && frame_ok;
  assign bad_pulse = load_pulse && armed_q && !frame_ok;
  assign fifo_pop  = out_valid && out_ready;

  // Phase tracking, arming, stage capture and sticky flags (a new event beats a clear).
  always_comb begin
    phase_d   = phase_q;
    armed_d   = armed_q | load_pulse;
    stg_vld_d = capture;
    stg_sum_d = capture ? sum_in : stg_sum_q;
    ovf_d     = ovf_q;
    ferr_d    = ferr_q;
    if (load_pulse) begin
      phase_d = '0;
    end else if (!frame_ok) begin
      phase_d = phase_q + PH_W'(1);
    end
    if (clr_flags) begin
      ovf_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (stg_vld_q && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
    if (bad_pulse) begin
      ferr_d = 1'b1;
    end
  end

  // Control and stage registers.
  always_ff @(posedge clk3) begin
    if (reset) begin
      phase_q   <= '0;
      armed_q   <= 1'b0;
      stg_vld_q <= 1'b0;
      stg_sum_q <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      armed_q   <= armed_d;
      stg_vld_q <= stg_vld_d;
      stg_sum_q <= stg_sum_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
    end
  end

  if (OUT_W == OUT_W_DEF) begin : g_pkg_scale
    sample_t smp;
    assign smp      = fir_round_sat(stg_sum_q, SHIFT);
    assign scl_data = smp.data;
    assign scl_sat  = smp.sat;
  end else begin : g_gen_scale
    localparam logic signed [SUM_W:0] RND = (SUM_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [SUM_W:0] HI  = (SUM_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [SUM_W:0] LO  = ~HI;
    logic signed [SUM_W:0] ext;
    logic signed [SUM_W:0] t;
    // Same round/clamp as the package helper, sized for a non-default output width.
    always_comb begin
      ext      = {stg_sum_q[SUM_W-1], stg_sum_q};
      t        = (ext + RND) >>> SHIFT;
      scl_sat  = 1'b0;
      scl_data = t[OUT_W-1:0];
      if (t > HI) begin
        scl_sat  = 1'b1;
        scl_data = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (t < LO) begin
        scl_sat  = 1'b1;
        scl_data = {1'b1, {(OUT_W-1){1'b0}}};
      end
    end
  end

  fir_out_fifo #(
    .W     (OUT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk3    (clk3),
    .reset   (reset),
    .push_i  (stg_vld_q),
    .wdat_i  ({scl_sat, scl_data}),
    .pop_i   (fifo_pop),
    .rdat_o  (fifo_rdat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign {out_sat, out_data} = fifo_rdat;
  assign out_valid           = !fifo_empty;
  assign overflow            = ovf_q;
  assign frame_err           = ferr_q;

endmodule

// File: tb/tb_fir_output_stage.sv
// Directed bench for fir_output_stage at default parameters.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Each scenario task carries its own hand-computed expectations.
module tb_fir_output_stage;

  logic        clk3 = 1'b0;
  logic        reset;
  logic [31:0] sum_in;
  logic        load_pulse;
  logic [15:0] out_data;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  level;
  logic        overflow;
  logic        frame_err;
  logic        clr_flags;

  int n_vec = 0;
  int n_err = 0;

  fir_output_stage dut (
    .clk3       (clk3),
    .reset      (reset),
    .sum_in     (sum_in),
    .load_pulse (load_pulse),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .clr_flags  (clr_flags)
  );

  always #5 clk3 = ~clk3;

  task automatic tick();
    @(posedge clk3);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One-cycle load strobe carrying sum s; returns in the cycle after the strobe.
  task automatic pulse(input logic [31:0] s);
    load_pulse = 1'b1;
    sum_in     = s;
    tick();
    load_pulse = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    load_pulse = 1'b0;
    sum_in     = '0;
    out_ready  = 1'b0;
    clr_flags  = 1'b0;
    do_reset();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL rst_data: got %h want 0000", out_data); end
    n_vec++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL rst_sat: got %b want 0", out_sat); end
    n_vec++; if (level !== 4'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
  endtask

  task automatic test_rounding();
    out_ready = 1'b1;
    pulse(32'hDEAD_BEEF);              // arming pulse, discarded
    idle(15);
    pulse(32'h0000_4000);              // 0.5 LSB rounds up to 1
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rnd_lat1: got %b want 0", out_valid); end
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rnd_lat2: got %b want 1", out_valid); end
    n_vec++; if (out_data !== 16'h0001) begin n_err++; $display("FAIL rnd_up: got %h want 0001", out_data); end
    n_vec++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL rnd_up_sat: got %b want 0", out_sat); end
    n_vec++; if (level !== 4'd1) begin n_err++; $display("FAIL rnd_level: got %0d want 1", level); end
    idle(14);
    pulse(32'hFFFF_C000);              // -0.5 LSB rounds up to 0
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rnd_neg_vld: got %b want 1", out_valid); end
    n_vec++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL rnd_neg: got %h want 0000", out_data); end
    n_vec++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL rnd_neg_sat: got %b want 0", out_sat); end
    idle(14);
  endtask

  task automatic test_saturation();
    pulse(32'h7FFF_FFFF);
    tick();
    n_vec++; if (out_data !== 16'h7FFF) begin n_err++; $display("FAIL sat_pos: got %h want 7fff", out_data); end
    n_vec++; if (out_sat !== 1'b1) begin n_err++; $display("FAIL sat_pos_flag: got %b want 1", out_sat); end
    idle(14);
    pulse(32'h8000_0000);
    tick();
    n_vec++; if (out_data !== 16'h8000) begin n_err++; $display("FAIL sat_neg: got %h want 8000", out_data); end
    n_vec++; if (out_sat !== 1'b1) begin n_err++; $display("FAIL sat_neg_flag: got %b want 1", out_sat); end
    idle(14);
  endtask

  task automatic test_first_pulse();
    do_reset();
    out_ready = 1'b1;
    pulse(32'h1234_0000);              // arms only
    idle(2);
    n_vec++; if (level !== 4'd0) begin n_err++; $display("FAIL first_level: got %0d want 0", level); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL first_valid: got %b want 0", out_valid); end
    idle(13);
    pulse(32'h1234_0000);
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL first_next_vld: got %b want 1", out_valid); end
    n_vec++; if (out_data !== 16'h2468) begin n_err++; $display("FAIL first_next_dat: got %h want 2468", out_data); end
    idle(14);
  endtask

  task automatic test_frame_err();
    pulse(32'h0001_8000);              // correctly spaced, value 3
    idle(9);
    pulse(32'h0100_0000);              // spacing 10: must be dropped
    n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_set: got %b want 1", frame_err); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ferr_drop: got %b want 0", out_valid); end
    n_vec++; if (level !== 4'd0) begin n_err++; $display("FAIL ferr_level: got %0d want 0", level); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_clr: got %b want 0", frame_err); end
    idle(13);
    pulse(32'h0002_8000);              // 16 after the bad pulse, value 5
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ferr_next_vld: got %b want 1", out_valid); end
    n_vec++; if (out_data !== 16'h0005) begin n_err++; $display("FAIL ferr_next_dat: got %h want 0005", out_data); end
    idle(14);
  endtask

  task automatic test_full();
    logic [15:0] exp_d [8];
    exp_d = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd10};
    out_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      pulse(32'(k) << 15);
      idle(15);
    end
    n_vec++; if (level !== 4'd8) begin n_err++; $display("FAIL full_level: got %0d want 8", level); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL full_ovf: got %b want 1", overflow); end
    n_vec++; if (out_data !== 16'd1) begin n_err++; $display("FAIL full_head: got %h want 0001", out_data); end
    pulse(32'(10) << 15);
    out_ready = 1'b1;                  // pop coincides with the push of value 10
    tick();
    n_vec++; if (level !== 4'd8) begin n_err++; $display("FAIL full_pushpop_level: got %0d want 8", level); end
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
        n_err++; $display("FAIL full_drain[%0d]: got vld=%b dat=%h want vld=1 dat=%h", i, out_valid, out_data, exp_d[i]);
      end
      tick();
    end
    n_vec++; if (out_valid !== 1'b0 || level !== 4'd0) begin
      n_err++; $display("FAIL full_empty: got vld=%b lvl=%0d want vld=0 lvl=0", out_valid, level);
    end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_ovf_clr: got %b want 0", overflow); end
    idle(14);
  endtask

  task automatic test_backpressure();
    logic [15:0] q [$];
    logic [15:0] held;
    logic        stalled;
    logic        r;
    out_ready = 1'b0;
    pulse(32'h11 << 15); q.push_back(16'h0011); idle(15);
    pulse(32'h22 << 15); q.push_back(16'h0022); idle(15);
    pulse(32'h33 << 15); q.push_back(16'h0033); idle(15);
    stalled = 1'b0;
    held    = '0;
    for (int c = 0; c < 200 && q.size() != 0; c++) begin
      n_vec++; if (out_valid !== 1'b1 || out_data !== q[0]) begin
        n_err++; $display("FAIL bp_head: got vld=%b dat=%h want vld=1 dat=%h", out_valid, out_data, q[0]);
      end
      if (stalled) begin
        n_vec++; if (out_data !== held) begin n_err++; $display("FAIL bp_stable: got %h want %h", out_data, held); end
      end
      r         = ($urandom_range(0, 1) != 0);
      out_ready = r;
      held      = out_data;
      stalled   = !r;
      tick();
      if (r) void'(q.pop_front());
    end
    n_vec++; if (q.size() != 0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_drain: got left=%0d vld=%b want left=0 vld=0", q.size(), out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    out_ready = 1'b0;
    pulse(32'(1) << 15); idle(15);
    pulse(32'(2) << 15); idle(15);
    pulse(32'(3) << 15); idle(4);
    pulse(32'h0700_0000);              // spacing 5: sets frame_err
    n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL mid_ferr: got %b want 1", frame_err); end
    n_vec++; if (level !== 4'd3) begin n_err++; $display("FAIL mid_level3: got %0d want 3", level); end
    idle(15);
    pulse(32'(4) << 15);               // captured, then lost to reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_vld: got %b want 0", out_valid); end
    n_vec++; if (level !== 4'd0) begin n_err++; $display("FAIL mid_rst_level: got %0d want 0", level); end
    n_vec++; if (frame_err !== 1'b0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_flags: got ferr=%b ovf=%b want 0 0", frame_err, overflow);
    end
    tick();
    n_vec++; if (level !== 4'd0) begin n_err++; $display("FAIL mid_inflight: got %0d want 0", level); end
    out_ready = 1'b1;
    pulse(32'(5) << 15);               // re-arms only
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rearm: got %b want 0", out_valid); end
    idle(14);
    pulse(32'(6) << 15);
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_data !== 16'h0006) begin
      n_err++; $display("FAIL mid_after: got vld=%b dat=%h want vld=1 dat=0006", out_valid, out_data);
    end
  endtask

  initial begin
    reset      = 1'b1;
    load_pulse = 1'b0;
    sum_in     = '0;
    out_ready  = 1'b0;
    clr_flags  = 1'b0;
    test_reset();
    test_rounding();
    test_saturation();
    test_first_pulse();
    test_frame_err();
    test_full();
    test_backpressure();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
